// File: rtl/imm_stage.sv
// imm_stage: decode-pipeline immediate generator. Extracts and extends the
// immediate for the selected format, forms pc + imm, flags illegal formats,
// and presents the result one cycle later on a valid/ready interface.
// SKID=1 uses a two-entry skid buffer with registered in_ready; SKID=0 uses a
// single output register with combinational in_ready.
module imm_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_type,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam logic [2:0] TYPE_I   = 3'b000;
    localparam logic [2:0] TYPE_S   = 3'b001;
    localparam logic [2:0] TYPE_B   = 3'b010;
    localparam logic [2:0] TYPE_U   = 3'b011;
    localparam logic [2:0] TYPE_J   = 3'b100;
    localparam logic [2:0] TYPE_Z   = 3'b101;
    localparam logic [2:0] TYPE_SH  = 3'b110;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_stage: XLEN must be 32 or 64");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Immediate decode (combinational, ahead of the register)
    // ------------------------------------------------------------------
    logic [31:0]     imm32;        // immediate already extended to 32 bits
    logic            fill;         // value replicated above bit 31 when XLEN=64
    logic            illegal_dec;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] target_dec;

    // Opcode bits never affect the immediate; the format comes from in_type.
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    // Select the immediate layout for the requested format.
    always_comb begin
        imm32       = '0;
        fill        = 1'b0;
        illegal_dec = 1'b0;
        case (in_type)
            TYPE_I: begin
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                fill  = in_instr[31];
            end
            TYPE_S: begin
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                fill  = in_instr[31];
            end
            TYPE_B: begin
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
                fill  = in_instr[31];
            end
            TYPE_U: begin
                imm32 = {in_instr[31:12], 12'b0};
                fill  = in_instr[31];
            end
            TYPE_J: begin
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
                fill  = in_instr[31];
            end
            TYPE_Z: begin
                imm32 = {27'b0, in_instr[19:15]};
            end
            TYPE_SH: begin
                imm32 = {26'b0, in_instr[25:20]};
                // A 6-bit shift amount is only meaningful on a 64-bit datapath.
                illegal_dec = (XLEN == 32) && in_instr[25];
            end
            default: begin
                imm32       = '0;
                illegal_dec = 1'b1;
            end
        endcase
    end

    // Widen to XLEN: low 32 bits from the decode, upper bits from fill.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi = gi + 1) begin : g_ext
            if (gi < 32) begin : g_lo
                assign imm_ext[gi] = imm32[gi];
            end else begin : g_hi
                assign imm_ext[gi] = fill;
            end
        end
    endgenerate

    // Target wraps modulo 2^XLEN by construction of the adder width.
    assign target_dec = in_pc + imm_ext;

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    logic            in_xfer;
    logic            out_xfer;
    logic            valid_reg;
    logic [XLEN-1:0] main_imm_reg;
    logic [XLEN-1:0] main_target_reg;
    logic            main_illegal_reg;

    assign in_xfer     = in_valid && in_ready;
    assign out_xfer    = valid_reg && out_ready;

    assign out_valid   = valid_reg;
    assign out_imm     = main_imm_reg;
    assign out_target  = main_target_reg;
    assign out_illegal = main_illegal_reg;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_FULL  = 2'd2
            } state_t;

            state_t          state_reg;
            logic            ready_reg;
            logic [XLEN-1:0] skid_imm_reg;
            logic [XLEN-1:0] skid_target_reg;
            logic            skid_illegal_reg;

            // in_ready comes from a flop; reset still forces it low.
            assign in_ready = rst_n && ready_reg;

            // Occupancy FSM: main register drains first, skid holds the
            // second entry taken while the consumer stalls.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg        <= ST_EMPTY;
                    ready_reg        <= 1'b1;
                    valid_reg        <= 1'b0;
                    main_imm_reg     <= '0;
                    main_target_reg  <= '0;
                    main_illegal_reg <= 1'b0;
                    skid_imm_reg     <= '0;
                    skid_target_reg  <= '0;
                    skid_illegal_reg <= 1'b0;
                end else if (in_flush) begin
                    state_reg <= ST_EMPTY;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                end else begin
                    case (state_reg)
                        ST_EMPTY: begin
                            if (in_xfer) begin
                                main_imm_reg     <= imm_ext;
                                main_target_reg  <= target_dec;
                                main_illegal_reg <= illegal_dec;
                                valid_reg        <= 1'b1;
                                state_reg        <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (in_xfer && out_xfer) begin
                                main_imm_reg     <= imm_ext;
                                main_target_reg  <= target_dec;
                                main_illegal_reg <= illegal_dec;
                            end else if (in_xfer) begin
                                skid_imm_reg     <= imm_ext;
                                skid_target_reg  <= target_dec;
                                skid_illegal_reg <= illegal_dec;
                                ready_reg        <= 1'b0;
                                state_reg        <= ST_FULL;
                            end else if (out_xfer) begin
                                valid_reg        <= 1'b0;
                                state_reg        <= ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (out_xfer) begin
                                main_imm_reg     <= skid_imm_reg;
                                main_target_reg  <= skid_target_reg;
                                main_illegal_reg <= skid_illegal_reg;
                                ready_reg        <= 1'b1;
                                state_reg        <= ST_ONE;
                            end
                        end
                        default: begin
                            state_reg <= ST_EMPTY;
                            ready_reg <= 1'b1;
                            valid_reg <= 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            // Accept whenever the register is free or being drained now.
            assign in_ready = rst_n && (!valid_reg || out_ready);

            // Single output register: load on accept, clear on drain.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg        <= 1'b0;
                    main_imm_reg     <= '0;
                    main_target_reg  <= '0;
                    main_illegal_reg <= 1'b0;
                end else if (in_flush) begin
                    valid_reg <= 1'b0;
                end else if (in_xfer) begin
                    valid_reg        <= 1'b1;
                    main_imm_reg     <= imm_ext;
                    main_target_reg  <= target_dec;
                    main_illegal_reg <= illegal_dec;
                end else if (out_xfer) begin
                    valid_reg <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_imm_stage.sv
// tb_imm_stage: directed bench for imm_stage. Instance A is XLEN=32 with the
// skid buffer, instance B is XLEN=64 with the single output register.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_imm_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_flush, a_valid, a_ready, a_out_valid, a_out_ready, a_illegal;
    logic [31:0] a_instr, a_pc, a_imm, a_target;
    logic [2:0]  a_type;

    logic        b_flush, b_valid, b_ready, b_out_valid, b_out_ready, b_illegal;
    logic [31:0] b_instr;
    logic [63:0] b_pc, b_imm, b_target;
    logic [2:0]  b_type;

    int errors = 0;
    int checks = 0;

    imm_stage #(.XLEN(32), .SKID(1)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_flush   (a_flush),
        .in_valid   (a_valid),
        .in_ready   (a_ready),
        .in_instr   (a_instr),
        .in_type    (a_type),
        .in_pc      (a_pc),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_imm    (a_imm),
        .out_target (a_target),
        .out_illegal(a_illegal)
    );

    imm_stage #(.XLEN(64), .SKID(0)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_flush   (b_flush),
        .in_valid   (b_valid),
        .in_ready   (b_ready),
        .in_instr   (b_instr),
        .in_type    (b_type),
        .in_pc      (b_pc),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_imm    (b_imm),
        .out_target (b_target),
        .out_illegal(b_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  t;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        ill;
    } vec32_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  t;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } vec64_t;

    // Present one entry to A for exactly one edge.
    task automatic send_a(input logic [31:0] instr, input logic [2:0] t, input logic [31:0] pc);
        a_instr = instr; a_type = t; a_pc = pc; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        $display("A xfer instr=%h type=%0d pc=%h -> valid=%b imm=%h tgt=%h ill=%b",
                 instr, t, pc, a_out_valid, a_imm, a_target, a_illegal);
    endtask

    // Present one entry to B for exactly one edge.
    task automatic send_b(input logic [31:0] instr, input logic [2:0] t, input logic [63:0] pc);
        b_instr = instr; b_type = t; b_pc = pc; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        $display("B xfer instr=%h type=%0d pc=%h -> valid=%b imm=%h tgt=%h ill=%b",
                 instr, t, pc, b_out_valid, b_imm, b_target, b_illegal);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_valid = 1'b1; a_instr = 32'hFFF00093; a_type = 3'd0; a_pc = 32'h100;
        b_valid = 1'b1; b_instr = 32'hFFF00093; b_type = 3'd0; b_pc = 64'h100;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid: got %b want 0", a_out_valid); end
        checks++; if (a_imm !== 32'h0) begin errors++; $display("FAIL rst_a_imm: got %h want 0", a_imm); end
        checks++; if (a_target !== 32'h0) begin errors++; $display("FAIL rst_a_target: got %h want 0", a_target); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready: got %b want 0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %b want 0", b_out_valid); end
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rel_a_ready: got %b want 1", a_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rel_a_valid: got %b want 0", a_out_valid); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rel_b_valid: got %b want 0", b_out_valid); end
        $display("reset done");
    endtask

    task automatic test_decode32;
        vec32_t v [12];
        v[0]  = '{32'hFFF00093, 3'd0, 32'h00000100, 32'hFFFFFFFF, 32'h000000FF, 1'b0};
        v[1]  = '{32'hFFDFF06F, 3'd4, 32'h00000200, 32'hFFFFFFFC, 32'h000001FC, 1'b0};
        v[2]  = '{32'hFE112C23, 3'd1, 32'h00001000, 32'hFFFFFFF8, 32'h00000FF8, 1'b0};
        v[3]  = '{32'h00000863, 3'd2, 32'h00000400, 32'h00000010, 32'h00000410, 1'b0};
        v[4]  = '{32'h80000063, 3'd2, 32'h00005000, 32'hFFFFF000, 32'h00004000, 1'b0};
        v[5]  = '{32'h12345037, 3'd3, 32'h00000010, 32'h12345000, 32'h12345010, 1'b0};
        v[6]  = '{32'h80000037, 3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0};
        v[7]  = '{32'hFFFFFFFF, 3'd5, 32'h00000000, 32'h0000001F, 32'h0000001F, 1'b0};
        v[8]  = '{32'h01F09093, 3'd6, 32'h00000100, 32'h0000001F, 32'h0000011F, 1'b0};
        v[9]  = '{32'h02009093, 3'd6, 32'h00000100, 32'h00000020, 32'h00000120, 1'b1};
        v[10] = '{32'hFFFFFFFF, 3'd7, 32'h00000040, 32'h00000000, 32'h00000040, 1'b1};
        v[11] = '{32'h7FF00093, 3'd0, 32'hFFFFFFF0, 32'h000007FF, 32'h000007EF, 1'b0};
        a_out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_a(v[i].instr, v[i].t, v[i].pc);
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL dec32[%0d] valid: got %b want 1", i, a_out_valid); end
            checks++; if (a_imm !== v[i].imm) begin errors++; $display("FAIL dec32[%0d] imm: got %h want %h", i, a_imm, v[i].imm); end
            checks++; if (a_target !== v[i].tgt) begin errors++; $display("FAIL dec32[%0d] target: got %h want %h", i, a_target, v[i].tgt); end
            checks++; if (a_illegal !== v[i].ill) begin errors++; $display("FAIL dec32[%0d] illegal: got %b want %b", i, a_illegal, v[i].ill); end
        end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL dec32 drain: got %b want 0", a_out_valid); end
    endtask

    task automatic test_decode64;
        vec64_t v [7];
        v[0] = '{32'h80000037, 3'd3, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};
        v[1] = '{32'hFFF00093, 3'd0, 64'h100, 64'hFFFFFFFFFFFFFFFF, 64'h00000000000000FF, 1'b0};
        v[2] = '{32'h02009093, 3'd6, 64'h100, 64'h0000000000000020, 64'h0000000000000120, 1'b0};
        v[3] = '{32'hFFFFFFFF, 3'd5, 64'h8000000000000000, 64'h000000000000001F, 64'h800000000000001F, 1'b0};
        v[4] = '{32'h7FF00093, 3'd0, 64'hFFFFFFFFFFFFFFF0, 64'h00000000000007FF, 64'h00000000000007EF, 1'b0};
        v[5] = '{32'hFFDFF06F, 3'd4, 64'h200, 64'hFFFFFFFFFFFFFFFC, 64'h00000000000001FC, 1'b0};
        v[6] = '{32'hFFFFFFFF, 3'd7, 64'h40, 64'h0, 64'h40, 1'b1};
        b_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_b(v[i].instr, v[i].t, v[i].pc);
            checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL dec64[%0d] valid: got %b want 1", i, b_out_valid); end
            checks++; if (b_imm !== v[i].imm) begin errors++; $display("FAIL dec64[%0d] imm: got %h want %h", i, b_imm, v[i].imm); end
            checks++; if (b_target !== v[i].tgt) begin errors++; $display("FAIL dec64[%0d] target: got %h want %h", i, b_target, v[i].tgt); end
            checks++; if (b_illegal !== v[i].ill) begin errors++; $display("FAIL dec64[%0d] illegal: got %b want %b", i, b_illegal, v[i].ill); end
        end
        @(posedge clk); #1;
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL dec64 drain: got %b want 0", b_out_valid); end
    endtask

    task automatic test_backpressure;
        a_out_ready = 1'b0;
        a_type = 3'd0; a_pc = 32'h0;
        a_instr = 32'h00100093; a_valid = 1'b1;          // A: imm 1
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b1 || a_imm !== 32'h1) begin errors++; $display("FAIL bp_A_out: got v=%b imm=%h want v=1 imm=1", a_out_valid, a_imm); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b want 1", a_ready); end
        a_instr = 32'h00200093;                            // B: imm 2
        @(posedge clk); #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", a_ready); end
        a_instr = 32'h00300093;                            // C: imm 3, must wait
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_c_wait[%0d] ready: got %b want 0", i, a_ready); end
            checks++; if (a_imm !== 32'h1 || a_target !== 32'h1) begin errors++; $display("FAIL bp_hold[%0d]: got imm=%h tgt=%h want 1/1", i, a_imm, a_target); end
        end
        $display("A stall: holding imm=%h with C pending", a_imm);
        a_out_ready = 1'b1;                                // A leaves at the next edge
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b1 || a_imm !== 32'h2) begin errors++; $display("FAIL bp_B_out: got v=%b imm=%h want v=1 imm=2", a_out_valid, a_imm); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: got %b want 1", a_ready); end
        @(posedge clk); #1;                                // C accepted, B leaves
        a_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_imm !== 32'h3) begin errors++; $display("FAIL bp_C_out: got v=%b imm=%h want v=1 imm=3", a_out_valid, a_imm); end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", a_out_valid); end
    endtask

    task automatic test_flush;
        a_out_ready = 1'b0;
        send_a(32'h00400093, 3'd0, 32'h0);
        send_a(32'h00500093, 3'd0, 32'h0);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL fl_full: got ready=%b want 0", a_ready); end
        a_flush = 1'b1; a_valid = 1'b1; a_instr = 32'h00600093; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_full_valid: got %b want 0", a_out_valid); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b want 1", a_ready); end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_capture: got %b want 0", a_out_valid); end
        send_a(32'h00700093, 3'd0, 32'h0);
        checks++; if (a_out_valid !== 1'b1 || a_imm !== 32'h7) begin errors++; $display("FAIL fl_after: got v=%b imm=%h want v=1 imm=7", a_out_valid, a_imm); end
        // Flush in ONE with an acceptable input: both the held and new entry vanish.
        a_flush = 1'b1; a_valid = 1'b1; a_instr = 32'h00800093;
        @(posedge clk); #1;
        a_flush = 1'b0; a_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_one_valid: got %b want 0", a_out_valid); end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_one_discard: got %b want 0", a_out_valid); end
        // Same discard on the single-register variant.
        b_out_ready = 1'b1;
        b_flush = 1'b1; b_valid = 1'b1; b_instr = 32'h00800093; b_type = 3'd0; b_pc = 64'h0;
        @(posedge clk); #1;
        b_flush = 1'b0; b_valid = 1'b0;
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL fl_b_discard: got %b want 0", b_out_valid); end
    endtask

    task automatic test_reset_midstall;
        a_out_ready = 1'b0;
        send_a(32'h00A00093, 3'd0, 32'h0);
        send_a(32'h00B00093, 3'd0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL rs_mid: got v=%b rdy=%b want 0/0", a_out_valid, a_ready); end
        rst_n = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL rs_after: got v=%b rdy=%b want 0/1", a_out_valid, a_ready); end
        send_a(32'h00900093, 3'd0, 32'h10);
        checks++; if (a_imm !== 32'h9 || a_target !== 32'h19) begin errors++; $display("FAIL rs_next: got imm=%h tgt=%h want 9/19", a_imm, a_target); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        a_type = 3'd0; b_type = 3'd0; a_pc = 32'h0; b_pc = 64'h0;
        for (int i = 1; i <= 4; i++) begin
            a_instr = 32'h00000093 | (32'(i + 16) << 20);
            b_instr = 32'h00000093 | (32'(i + 32) << 20);
            a_valid = 1'b1; b_valid = 1'b1;
            @(posedge clk); #1;
            $display("b2b cycle %0d: A imm=%h B imm=%h", i, a_imm, b_imm);
            checks++; if (a_out_valid !== 1'b1 || a_imm !== 32'(i + 16)) begin errors++; $display("FAIL b2b_a[%0d]: got v=%b imm=%h want %h", i, a_out_valid, a_imm, 32'(i + 16)); end
            checks++; if (b_out_valid !== 1'b1 || b_imm !== 64'(i + 32)) begin errors++; $display("FAIL b2b_b[%0d]: got v=%b imm=%h want %h", i, b_out_valid, b_imm, 64'(i + 32)); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got a=%b b=%b want 0/0", a_out_valid, b_out_valid); end
    endtask

    task automatic test_single_stall;
        b_out_ready = 1'b0;
        send_b(32'h02100093, 3'd0, 64'h0);                 // imm 0x21
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL s0_ready_low: got %b want 0", b_ready); end
        b_instr = 32'h02200093; b_valid = 1'b1;            // imm 0x22 waits
        @(posedge clk); #1;
        checks++; if (b_imm !== 64'h21 || b_out_valid !== 1'b1) begin errors++; $display("FAIL s0_hold: got v=%b imm=%h want 1/21", b_out_valid, b_imm); end
        b_out_ready = 1'b1;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL s0_ready_comb: got %b want 1", b_ready); end
        @(posedge clk); #1;
        b_valid = 1'b0;
        checks++; if (b_imm !== 64'h22 || b_out_valid !== 1'b1) begin errors++; $display("FAIL s0_next: got v=%b imm=%h want 1/22", b_out_valid, b_imm); end
        @(posedge clk); #1;
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL s0_drain: got %b want 0", b_out_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 1'b0; a_valid = 1'b0; a_out_ready = 1'b1;
        a_instr = '0; a_type = '0; a_pc = '0;
        b_flush = 1'b0; b_valid = 1'b0; b_out_ready = 1'b1;
        b_instr = '0; b_type = '0; b_pc = '0;
        #1;
        test_reset();
        test_decode32();
        test_decode64();
        test_backpressure();
        test_flush();
        test_reset_midstall();
        test_back_to_back();
        test_single_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_stage.md
# imm_stage

Registered, handshaked immediate-generation stage for the decode pipeline, parametrised in datapath width and buffering mode. It accepts a raw 32-bit instruction, an immediate-type code and the instruction PC. It produces:
- the sign- or zero-extended immediate at XLEN bits,
- the PC-relative target (pc + imm),
- an illegal-format flag,

all one cycle later on a valid/ready interface. It sits between fetch/instruction-buffer and the register-read stage, and adds CSR-zimm and shift-amount formats plus flush and backpressure handling.

## Interface
- XLEN, 32: immediate, PC and target width; legal values 32 or 64.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.
- clk  input  1  clock, all logic rising-edge.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in_flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  input entry valid.
- in_ready  output  1  stage can accept input this cycle.
- in_instr  input  32  raw instruction.
- in_type  input  3  immediate format code.
- in_pc  input  XLEN  PC of the instruction.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts output.
- out_imm  output  XLEN  extended immediate.
- out_target  output  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_illegal  output  1  format invalid for this XLEN/type.

## Operation
- Type decode (sx = sign-extend from instr[31] to XLEN):
  - 000 I: sx(instr[31:20])
  - 001 S: sx({instr[31:25], instr[11:7]})
  - 010 B: sx({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - 011 U: sx({instr[31:12], 12'b0}), so bits above 31 copy instr[31] when XLEN=64
  - 100 J: sx({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - 101 Z: zero-extended instr[19:15] (CSR zimm)
  - 110 SH: zero-extended instr[25:20]; if XLEN=32 and instr[25]=1, set illegal
  - 111: imm = 0, illegal = 1
- Target:
  - out_target = in_pc + imm, computed before the register.
  - Overflow wraps.
  - Computed for every type; the consumer decides whether to use it.
- Transfer rules:
  - An input transfer occurs when in_valid and in_ready are both high.
  - An output transfer occurs when out_valid and out_ready are both high.
  - Order is strictly preserved; no entry is dropped or duplicated except by flush.
- SKID=0:
  - in_ready = !out_valid || out_ready.
  - On an input transfer the output register loads the new entry.
  - On an output transfer with no input transfer, out_valid clears.
- SKID=1: state machine EMPTY / ONE / FULL (0, 1, 2 entries). Entry order is main register, then skid register.
  - in_ready = (state != FULL), registered.
  - EMPTY: input transfer loads main → ONE.
  - ONE: in only → skid loads → FULL. Out only → EMPTY. In and out together → main reloads, stays ONE.
  - FULL: out transfer moves skid to main → ONE. No input is accepted.
- Flush:
  - in_flush=1 forces EMPTY (out_valid=0) at the next edge.
  - Any in_valid in the same cycle is discarded.
  - Flush takes priority over the output transfer.
- Stall hold: while out_valid=1 and out_ready=0, out_imm, out_target and out_illegal are stable.

## Timing
- Reset (rst_n low at an edge):
  - out_valid=0, out_imm=0, out_target=0, out_illegal=0.
  - SKID=1: state EMPTY and in_ready=1 from the first cycle after reset.
  - While rst_n is low, in_ready=0 and inputs are ignored.
- Latency: an input transfer at edge N gives out_valid=1 with that data after edge N, i.e. one cycle.
- Throughput: one entry per cycle when out_ready=1, in both modes.
- SKID=1 backpressure:
  - After out_ready falls, up to two entries are accepted.
  - in_ready drops in the cycle after the second acceptance.
  - in_ready rises in the cycle after the first output transfer from FULL.
- Reset or flush mid-stall: all entries are lost. The next accepted entry appears one cycle after acceptance.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, out_imm=0, in_ready=0. After release, in_ready=1 (SKID=1) and no spurious output.
- I-type: in_instr=0xFFF00093, in_pc=0x100 → next cycle out_imm=0xFFFFFFFF, out_target=0x000000FF, out_illegal=0.
- J-type: in_instr=0xFFDFF06F, in_pc=0x200 → out_imm=0xFFFFFFFC, out_target=0x1FC.
- XLEN=64, U-type: in_instr=0x80000037 → out_imm=0xFFFFFFFF80000000.
- SKID=1 backpressure:
  - Hold out_ready=0 and present A, B, C back-to-back → A and B accepted, in_ready=0 while C waits.
  - Raise out_ready → outputs A, B, C on consecutive cycles, no loss.
- Flush and illegal cases:
  - In FULL, assert in_flush with in_valid=1 → out_valid=0 next cycle, new entry not captured.
  - XLEN=32, type 110, in_instr=0x02009093 → out_illegal=1.
  - Type 111 → out_imm=0, out_illegal=1.
